counter_buffer_reader: RTL and testbench
========================================

# counter_buffer_reader

Streaming read-out engine for the counter sample SRAM. It owns the SRAM's second (read-only) port and drains entries in write order from a circular buffer whose fill pointer comes from the counter write logic. It presents the entries as a valid/ready stream toward the system-bus/DMA side. It feeds its consumed pointer back to the writer for full detection, and reports fill level and producer overrun.

## Interface
- `ADDR_WIDTH`, default 12: SRAM address width.
- `DATA_WIDTH`, default 18: SRAM word width.
- `DEPTH`, default 4096: buffer entries; must equal 2**ADDR_WIDTH.

Ports:
- `i_clk`  in  1  sole clock; all logic on rising edge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_wr_ptr`  in  ADDR_WIDTH+1  writer's next-write pointer including wrap bit; counts only entries already committed to SRAM at an earlier edge.
- `o_sram_addr`  out  ADDR_WIDTH  SRAM read-port address. The parent ties that port's write enable to 0.
- `i_sram_data`  in  DATA_WIDTH  SRAM read-port data; valid one cycle after the address edge.
- `o_rd_ptr`  out  ADDR_WIDTH+1  consumed pointer including wrap bit; fed back to the writer.
- `o_data`  out  DATA_WIDTH  stream data.
- `o_valid`  out  1  stream valid.
- `i_ready`  in  1  stream ready.
- `i_flush`  in  1  single-cycle request to discard all unread data.
- `o_level`  out  ADDR_WIDTH+1  registered unread-entry count, `i_wr_ptr - o_rd_ptr` modulo 2**(ADDR_WIDTH+1).
- `o_overrun`  out  1  sticky producer-overrun flag.

## Operation
- **Pointers**
  - `f_ptr` (fetch) tracks addresses issued. `o_rd_ptr` tracks entries accepted downstream. Both are ADDR_WIDTH+1 bits and wrap naturally.
  - `o_sram_addr = f_ptr[ADDR_WIDTH-1:0]`.
- **Output skid buffer**
  - 2 entries, plus a 1-bit in-flight flag for the outstanding SRAM read.
  - A read is issued (`f_ptr++`, in-flight set) at an edge when all of these hold: `f_ptr != i_wr_ptr`, no flush, and `count + inflight - pop < 2`, where `pop = o_valid & i_ready`.
  - The in-flight response is pushed into the skid buffer at the next edge.
- **Stream handshake**
  - `o_valid = (count != 0)`; `o_data` = skid head.
  - On `pop`: `o_rd_ptr++` and the head advances.
  - `o_data`/`o_valid` hold stable while `o_valid & ~i_ready`.
- **States**
  - EMPTY: `count = 0`, not in flight.
  - STREAM: any data buffered or in flight.
  - FLUSH: one cycle after `i_flush`, during which any in-flight response is discarded.
  - Transitions: EMPTY→STREAM on issue. STREAM→EMPTY when the last entry pops and nothing is pending. Any→FLUSH on `i_flush`. FLUSH→EMPTY unconditionally.
- **Flush**
  - At the `i_flush` edge: `f_ptr` and `o_rd_ptr` are loaded from `i_wr_ptr`, `count` is cleared, and `o_overrun` is cleared.
  - Flush has priority over simultaneous pop and issue.
  - No read is issued in the FLUSH cycle.
- **Arithmetic and empty/full**
  - All pointer math is modulo 2**(ADDR_WIDTH+1).
  - Empty: `f_ptr == i_wr_ptr`.
  - A full buffer (`o_level == DEPTH`) is legal and drains normally.
- **Reset mid-operation** returns everything to reset values immediately. Buffered and in-flight data are lost.

## Timing
- **Reset values:** `o_sram_addr` 0, `o_rd_ptr` 0, `o_data` 0, `o_valid` 0, `o_level` 0, `o_overrun` 0; state EMPTY.
- **Latency:** with the reader empty, when `i_wr_ptr` increments (first sampled at edge c), the read issues at edge c and `o_valid` rises after edge c+1.
- **Throughput:** 1 entry/cycle sustained while `i_ready` = 1 and data is available.
- **Ready low:** once `i_ready` deasserts, the buffer fills to 2 and issue stops within one cycle.
- **`o_level`** is registered: 1-cycle lag relative to its inputs.

## Configuration
- `COUNTER_READER_OVERRUN_EN` defined:
  - `o_overrun` is set at any edge where the computed level (`i_wr_ptr - o_rd_ptr`) exceeds DEPTH.
  - It stays set until `i_flush` or reset.
  - Streaming continues unchanged; the data is unreliable.
- Not defined: `o_overrun` is constant 0 and the comparator logic is absent.

## Test plan
- **Reset:** assert `i_rst` mid-stream with 2 entries buffered -> all outputs 0 immediately; `o_valid` stays 0 while `i_wr_ptr` = 0.
- **Single entry:** SRAM[0]=0x155, `i_wr_ptr` 0->1, `i_ready`=1 -> `o_valid` rises 2 cycles later with `o_data`=0x155; then `o_rd_ptr`=1, `o_level`=0.
- **Wrap-around:** `i_wr_ptr` advances from 4094 to 4098 with `i_ready`=1 -> addresses 4094, 4095, 0, 1 are read in order; `o_rd_ptr` ends at 4098, back-to-back with no bubbles.
- **Backpressure:** 10 entries pending, `i_ready` toggling 1,0,0,1 -> no entry lost or duplicated, `o_data` stable while stalled, and never more than 1 read in flight beyond 2 buffered.
- **Flush with read in flight:** `i_flush` pulsed during an outstanding read -> in-flight data dropped, `o_rd_ptr` = `i_wr_ptr`, `o_valid`=0 for at least 2 cycles.
- **Overrun (macro defined):** `i_wr_ptr` jumps to `o_rd_ptr`+4097 -> `o_overrun`=1 after the next edge and stays 1; `i_flush` clears it. Macro undefined -> `o_overrun` stays 0.

Source files
------------

// File: rtl/counter_buffer_reader.sv
// -----------------------------------------------------------------------------
// counter_buffer_reader
//
// Streaming read-out engine for the counter sample SRAM. Owns the SRAM read
// port, drains the circular buffer in write order and presents the entries as
// a valid/ready stream. A two-entry skid buffer plus one outstanding SRAM read
// keeps the stream at one entry per cycle while absorbing backpressure.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_wr_ptr     writer's next-write pointer (with wrap bit)
//   o_sram_addr  SRAM read address (fetch pointer, wrap bit dropped)
//   i_sram_data  SRAM read data, valid one cycle after the address edge
//   o_rd_ptr     consumed pointer (with wrap bit), fed back to the writer
//   o_data       stream data (skid head)
//   o_valid      stream valid
//   i_ready      stream ready
//   i_flush      single-cycle request to discard all unread data
//   o_level      registered unread-entry count
//   o_overrun    sticky producer-overrun flag
//
// Build option:
//   COUNTER_READER_OVERRUN_EN  when defined, o_overrun is set whenever the
//                              unread count exceeds DEPTH; otherwise it is
//                              tied to 0.
// -----------------------------------------------------------------------------
module counter_buffer_reader #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 18,
  parameter int DEPTH      = 4096
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [ADDR_WIDTH:0]   i_wr_ptr,
  output logic [ADDR_WIDTH-1:0] o_sram_addr,
  input  logic [DATA_WIDTH-1:0] i_sram_data,
  output logic [ADDR_WIDTH:0]   o_rd_ptr,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  input  logic                  i_flush,
  output logic [ADDR_WIDTH:0]   o_level,
  output logic                  o_overrun
);

  localparam int PW = ADDR_WIDTH + 1;

  if (DEPTH != (1 << ADDR_WIDTH)) begin : g_depth_chk
    $error("DEPTH must equal 2**ADDR_WIDTH");
  end

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [PW-1:0]         f_ptr_q, f_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         level_q, level_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] skid0_q, skid0_d;
  logic [DATA_WIDTH-1:0] skid1_q, skid1_d;

  logic                  pop;
  logic                  issue;
  logic [2:0]            occ;
  logic [1:0]            cnt_after_pop;

  assign pop = (cnt_q != 2'd0) & i_ready;

  // Occupancy the skid buffer will have once the current pop and the
  // outstanding response are accounted for; a new read may only be issued
  // if its response is guaranteed a free slot.
  assign occ = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};

  assign issue = (f_ptr_q != i_wr_ptr) && !i_flush && (state_q != ST_FLUSH) &&
                 (occ < 3'd2);

  always_comb begin
    state_d       = state_q;
    f_ptr_d       = f_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    inflight_d    = inflight_q;
    cnt_d         = cnt_q;
    skid0_d       = skid0_q;
    skid1_d       = skid1_q;
    cnt_after_pop = cnt_q;

    if (i_flush) begin
      // Flush wins over pop and issue; an outstanding response is dropped
      // by clearing the in-flight flag.
      f_ptr_d    = i_wr_ptr;
      rd_ptr_d   = i_wr_ptr;
      cnt_d      = 2'd0;
      inflight_d = 1'b0;
      state_d    = ST_FLUSH;
    end else begin
      if (pop) begin
        skid0_d       = skid1_q;
        cnt_after_pop = cnt_q - 2'd1;
        rd_ptr_d      = rd_ptr_q + PW'(1);
      end

      if (inflight_q) begin
        if (cnt_after_pop == 2'd0) begin
          skid0_d = i_sram_data;
        end else begin
          skid1_d = i_sram_data;
        end
        cnt_d = cnt_after_pop + 2'd1;
      end else begin
        cnt_d = cnt_after_pop;
      end

      if (issue) begin
        f_ptr_d = f_ptr_q + PW'(1);
      end
      inflight_d = issue;

      if (state_q == ST_FLUSH) begin
        state_d = ST_EMPTY;
      end else if ((cnt_d != 2'd0) || inflight_d) begin
        state_d = ST_STREAM;
      end else begin
        state_d = ST_EMPTY;
      end
    end

    // Level is taken against the post-edge consumed pointer so a flush
    // reports zero immediately.
    level_d = i_wr_ptr - rd_ptr_d;
  end

`ifdef COUNTER_READER_OVERRUN_EN
  logic          overrun_q, overrun_d;
  logic [PW-1:0] level_now;

  assign level_now = i_wr_ptr - rd_ptr_q;

  always_comb begin
    overrun_d = overrun_q;
    if (i_flush) begin
      overrun_d = 1'b0;
    end else if ({1'b0, level_now} > (PW + 1)'(DEPTH)) begin
      overrun_d = 1'b1;
    end
  end

  assign o_overrun = overrun_q;
`else
  assign o_overrun = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_EMPTY;
      f_ptr_q    <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      inflight_q <= 1'b0;
      cnt_q      <= 2'd0;
      skid0_q    <= '0;
      skid1_q    <= '0;
`ifdef COUNTER_READER_OVERRUN_EN
      overrun_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      f_ptr_q    <= f_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
      skid0_q    <= skid0_d;
      skid1_q    <= skid1_d;
`ifdef COUNTER_READER_OVERRUN_EN
      overrun_q  <= overrun_d;
`endif
    end
  end

  assign o_sram_addr = f_ptr_q[ADDR_WIDTH-1:0];
  assign o_rd_ptr    = rd_ptr_q;
  assign o_data      = skid0_q;
  assign o_valid     = (cnt_q != 2'd0);
  assign o_level     = level_q;

endmodule

// File: tb/tb_counter_buffer_reader.sv
// -----------------------------------------------------------------------------
// tb_counter_buffer_reader
//
// Drives counter_buffer_reader with a behavioural SRAM and writer, and checks
// the stream against a queue of produced entries, plus pointer, level,
// overrun and stall-stability expectations derived from the read-out rules.
// -----------------------------------------------------------------------------
module tb_counter_buffer_reader;

  localparam int AW    = 12;
  localparam int DW    = 18;
  localparam int DEPTH = 4096;

  logic          clk;
  logic          rst;
  logic [AW:0]   wr_ptr;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_data;
  logic [AW:0]   rd_ptr;
  logic [DW-1:0] data;
  logic          valid;
  logic          ready;
  logic          flush;
  logic [AW:0]   level;
  logic          overrun;

  counter_buffer_reader #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_wr_ptr    (wr_ptr),
    .o_sram_addr (sram_addr),
    .i_sram_data (sram_data),
    .o_rd_ptr    (rd_ptr),
    .o_data      (data),
    .o_valid     (valid),
    .i_ready     (ready),
    .i_flush     (flush),
    .o_level     (level),
    .o_overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM read port: registered, one cycle latency.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) sram_data <= mem[sram_addr];

`ifdef COUNTER_READER_OVERRUN_EN
  localparam bit OV_EXP = 1'b1;
`else
  localparam bit OV_EXP = 1'b0;
`endif

  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;
  logic [DW-1:0] q [$];
  logic [DW-1:0] next_val [$];
  int            pop_cyc [$];
  logic [AW:0]   rd_model  = '0;
  logic [AW:0]   lvl_model = '0;
  logic          ov_model  = 1'b0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic produce();
    logic [DW-1:0] v;
    if (next_val.size() > 0) v = next_val.pop_front();
    else v = DW'($urandom);
    mem[wr_ptr[AW-1:0]] = v;
    q.push_back(v);
    wr_ptr = wr_ptr + 1'b1;
  endtask

  // One clock cycle: check the state left by the previous edge, drive new
  // inputs, then predict what the coming edge does.
  task automatic cycle(input bit rdy, input bit fl, input int nprod);
    logic [AW:0] diff;
    @(negedge clk);
    cyc++;
    chk("rd_ptr", rd_ptr, rd_model);
    chk("level", level, lvl_model);
    chk("overrun", overrun, ov_model);
    chk("fetch_bound", (12'(sram_addr - rd_model[AW-1:0]) <= 12'd3), 1);
    chk("valid_extra", valid && (q.size() == 0), 0);
    if (prev_stall) begin
      chk("stall_vld", valid, 1);
      chk("stall_data", data, prev_data);
    end
    for (int i = 0; i < nprod; i++) produce();
    ready = rdy;
    flush = fl;
    #1;
    diff = wr_ptr - rd_model;
    prev_stall = 1'b0;
    if (fl) begin
      q.delete();
      rd_model = wr_ptr;
      ov_model = 1'b0;
    end else begin
      if (OV_EXP && (diff > 13'(DEPTH))) ov_model = 1'b1;
      if (valid && rdy) begin
        if (q.size() > 0) chk("data", data, q.pop_front());
        rd_model = rd_model + 1'b1;
        pop_cyc.push_back(cyc);
      end else if (valid) begin
        prev_stall = 1'b1;
        prev_data  = data;
      end
    end
    lvl_model = wr_ptr - rd_model;
  endtask

  task automatic drain();
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    rst = 1'b1; wr_ptr = '0; ready = 1'b0; flush = 1'b0;
    #12;
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_rd_ptr", rd_ptr, 0);
    chk("rst_level", level, 0);
    chk("rst_overrun", overrun, 0);
    @(negedge clk);
    rst = 1'b0;

    // Single entry: o_valid two cycles after the pointer moves.
    next_val.push_back(18'h155);
    cycle(1'b1, 1'b0, 1);
    cycle(1'b1, 1'b0, 0);
    chk("single_vld_early", valid, 0);
    cycle(1'b1, 1'b0, 0);
    chk("single_vld", valid, 1);
    chk("single_data", data, 18'h155);
    cycle(1'b1, 1'b0, 0);
    cycle(1'b1, 1'b0, 0);
    chk("single_rd", rd_ptr, 1);
    chk("single_lvl", level, 0);

    // Backpressure: 10 entries with ready pattern 1,0,0,1.
    cycle(1'b1, 1'b0, 10);
    for (int i = 0; i < 40; i++) cycle((i % 4 == 0) || (i % 4 == 3), 1'b0, 0);
    drain();
    chk("bp_empty", q.size(), 0);

    // Flush while a read is outstanding.
    cycle(1'b1, 1'b0, 3);
    cycle(1'b1, 1'b1, 0);
    cycle(1'b1, 1'b0, 0);
    chk("flush_vld0", valid, 0);
    chk("flush_rd", rd_ptr, wr_ptr);
    cycle(1'b1, 1'b0, 0);
    chk("flush_vld1", valid, 0);
    drain();

    // Wrap-around: move both pointers to 4094 via flush, then stream 4.
    n = int'(13'(13'd4094 - wr_ptr));
    cycle(1'b1, 1'b1, n);
    cycle(1'b1, 1'b0, 0);
    pop_cyc.delete();
    cycle(1'b1, 1'b0, 4);
    drain();
    chk("wrap_rd", rd_ptr, 13'd4098);
    chk("wrap_pops", pop_cyc.size(), 4);
    if (pop_cyc.size() == 4) chk("wrap_burst", pop_cyc[3] - pop_cyc[0], 3);

    // Overrun: writer jumps DEPTH+1 ahead of the consumed pointer.
    cycle(1'b0, 1'b0, DEPTH + 1);
    cycle(1'b0, 1'b0, 0);
    chk("ovr_set", overrun, OV_EXP);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 0);
    chk("ovr_hold", overrun, OV_EXP);
    cycle(1'b0, 1'b1, 0);
    cycle(1'b0, 1'b0, 0);
    chk("ovr_clr", overrun, 0);
    drain();

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 800; i++) begin
      n = (lvl_model > 13'd4000) ? 0 : int'($urandom_range(0, 2));
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0, n);
    end
    drain();

    // Reset mid-stream with two entries buffered.
    cycle(1'b0, 1'b0, 5);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 0);
    chk("pre_rst_vld", valid, 1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("mrst_valid", valid, 0);
    chk("mrst_data", data, 0);
    chk("mrst_addr", sram_addr, 0);
    chk("mrst_rd_ptr", rd_ptr, 0);
    chk("mrst_level", level, 0);
    chk("mrst_overrun", overrun, 0);
    wr_ptr = '0;
    q.delete();
    rd_model = '0; lvl_model = '0; ov_model = 1'b0; prev_stall = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 0);
      chk("post_rst_vld", valid, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
